// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, forwarding-select
// encodings and the control bundle driven by the hazard unit.
package control_itf;

    // Forwarding mux select encodings for the EX-stage operand muxes.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    // Hazard unit FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hazard_state_t;

    // Control bundle: operand forwarding selects plus per-stage pipe
    // register loads and synchronous pipe register resets.
    typedef struct packed {
        logic [1:0] rs1mux_sel;
        logic [1:0] rs2mux_sel;
        logic       pipe_load_ifid;
        logic       pipe_load_idex;
        logic       pipe_load_exmem;
        logic       pipe_load_memwb;
        logic       pipe_rst_ifid;
        logic       pipe_rst_idex;
        logic       pipe_rst_exmem;
        logic       pipe_rst_memwb;
    } control;

    // Register-match helper: a write to x0 never forwards.
    function automatic logic rd_match(input logic       load_regfile,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
        return load_regfile && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// Operand forwarding selector for one EX-stage source register. The youngest
// producer (EX/MEM) wins over the older one (MEM/WB).
module forward_sel
    import control_itf::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_load_regfile,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_load_regfile,
    output logic [1:0] sel
);

    // Pick the most recent in-flight producer of rs, else the register file.
    always_comb begin
        sel = FWD_REGFILE;
        if (rd_match(exmem_load_regfile, exmem_rd, rs)) begin
            sel = FWD_EXMEM;
        end else if (rd_match(memwb_load_regfile, memwb_rd, rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// cache-miss freeze and stall/flush performance counters.
module hazard_ctrl
    import control_itf::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idex_rs1,
    input  logic [4:0]  idex_rs2,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic [4:0]  idex_rd,
    input  logic        idex_dcache_read,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_load_regfile,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_load_regfile,
    input  logic        br_taken,
    input  logic        icache_read,
    input  logic        icache_resp,
    input  logic        dcache_req,
    input  logic        dcache_resp,
    output control      ctrl,
    output logic        pc_load,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    hazard_state_t state;
    hazard_state_t next_state;

    logic       i_done;
    logic       d_done;
    logic       i_pend;
    logic       d_pend;
    logic       mem_busy;
    logic       lu_match;
    logic       br_flush;
    logic       lu_stall;
    logic [1:0] rs1_sel;
    logic [1:0] rs2_sel;

    forward_sel u_fwd_rs1 (
        .rs                 (idex_rs1),
        .exmem_rd           (exmem_rd),
        .exmem_load_regfile (exmem_load_regfile),
        .memwb_rd           (memwb_rd),
        .memwb_load_regfile (memwb_load_regfile),
        .sel                (rs1_sel)
    );

    forward_sel u_fwd_rs2 (
        .rs                 (idex_rs2),
        .exmem_rd           (exmem_rd),
        .exmem_load_regfile (exmem_load_regfile),
        .memwb_rd           (memwb_rd),
        .memwb_load_regfile (memwb_load_regfile),
        .sel                (rs2_sel)
    );

    // A request is still outstanding until its response has been seen once
    // during the current freeze; the done flags remember earlier responses
    // so a port that finished first does not keep the pipe frozen.
    assign i_pend   = icache_read & ~icache_resp & ~i_done;
    assign d_pend   = dcache_req  & ~dcache_resp & ~d_done;
    assign mem_busy = i_pend | d_pend;

    // Load in EX whose destination is read by the instruction in ID.
    assign lu_match = idex_dcache_read && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    // Memory freeze beats the branch flush, which beats the load-use stall.
    // A branch seen during a freeze simply waits in EX; the release cycle
    // (all responses in) behaves as the first RUN cycle and acts on it.
    // The single load-use bubble cycle never re-detects the same hazard.
    assign br_flush = ~mem_busy & br_taken;
    assign lu_stall = ~mem_busy & ~br_taken & lu_match & (state != LU_STALL);

    // Next-state decode for the hazard FSM.
    always_comb begin
        next_state = RUN;
        case (state)
            RUN:      next_state = mem_busy ? MEM_WAIT :
                                   (lu_stall ? LU_STALL : RUN);
            LU_STALL: next_state = RUN;
            MEM_WAIT: next_state = mem_busy ? MEM_WAIT :
                                   (lu_stall ? LU_STALL : RUN);
            default:  next_state = RUN;
        endcase
    end

    // FSM state and per-port response tracking; reset abandons any stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state <= next_state;
            if (mem_busy) begin
                i_done <= i_done | (icache_read & icache_resp);
                d_done <= d_done | (dcache_req & dcache_resp);
            end else begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end
        end
    end

    // Pipe register loads/resets and PC enable for the current cycle.
    always_comb begin
        ctrl    = '0;
        pc_load = 1'b0;
        if (rst) begin
            ctrl.pipe_rst_ifid  = 1'b1;
            ctrl.pipe_rst_idex  = 1'b1;
            ctrl.pipe_rst_exmem = 1'b1;
            ctrl.pipe_rst_memwb = 1'b1;
        end else if (mem_busy) begin
            pc_load = 1'b0;
        end else if (br_flush) begin
            pc_load              = 1'b1;
            ctrl.pipe_load_ifid  = 1'b1;
            ctrl.pipe_load_idex  = 1'b1;
            ctrl.pipe_load_exmem = 1'b1;
            ctrl.pipe_load_memwb = 1'b1;
            ctrl.pipe_rst_ifid   = 1'b1;
            ctrl.pipe_rst_idex   = 1'b1;
        end else if (lu_stall) begin
            pc_load              = 1'b0;
            ctrl.pipe_load_ifid  = 1'b0;
            ctrl.pipe_load_idex  = 1'b1;
            ctrl.pipe_load_exmem = 1'b1;
            ctrl.pipe_load_memwb = 1'b1;
            ctrl.pipe_rst_idex   = 1'b1;
        end else begin
            pc_load              = 1'b1;
            ctrl.pipe_load_ifid  = 1'b1;
            ctrl.pipe_load_idex  = 1'b1;
            ctrl.pipe_load_exmem = 1'b1;
            ctrl.pipe_load_memwb = 1'b1;
        end
        ctrl.rs1mux_sel = rst ? FWD_REGFILE : rs1_sel;
        ctrl.rs2mux_sel = rst ? FWD_REGFILE : rs2_sel;
    end

    // Performance counters: PC-frozen cycles and issued branch flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!pc_load) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (br_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

endmodule
